// File: rtl/fir_seq_mac.sv
// fir_seq_mac: sequential single-multiplier FIR with saturated, scaled unsigned output.
// Define FIR_SEQ_MAC_ROUND_EN for round-half-up before the shift; otherwise the result is truncated.
module fir_seq_mac #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy
);
    localparam int KW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [ACC_W:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t              r_state, w_next;
    logic [DATA_W-1:0]   r_x [TAPS];
    logic [COEF_W-1:0]   r_h [TAPS];
    logic [ACC_W-1:0]    r_acc;
    logic [KW-1:0]       r_k;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [PW-1:0]       w_prod;
    logic [ACC_W:0]      w_rnd;
    logic [ACC_W:0]      w_shr;
    logic [DATA_W-1:0]   w_sat;
    assign w_prod = {{COEF_W{1'b0}}, r_x[r_k]} * {{DATA_W{1'b0}}, r_h[r_k]};
`ifdef FIR_SEQ_MAC_ROUND_EN
    assign w_rnd = {1'b0, r_acc} + (ONE << (SHIFT - 1));
`else
    assign w_rnd = {1'b0, r_acc};
`endif
    assign w_shr = w_rnd >> SHIFT;
    assign w_sat = |w_shr[ACC_W:DATA_W] ? {DATA_W{1'b1}} : w_shr[DATA_W-1:0];
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        if (r_state == IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
            w_next   = in_valid ? MAC : IDLE;
        end else if (r_state == MAC) begin
            w_next = (r_k == KW'(TAPS - 1)) ? DONE : MAC;
        end else begin
            w_next = (r_out_valid && out_ready) ? IDLE : DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
            r_acc       <= '0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == IDLE && coef_we) r_h[coef_addr] <= coef_data;
            if (r_state == IDLE && in_valid) begin
                for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
                r_x[0] <= in_data;
                r_acc  <= '0;
                r_k    <= '0;
            end
            if (r_state == MAC) begin
                r_acc <= r_acc + {{(ACC_W - PW){1'b0}}, w_prod};
                r_k   <= r_k + KW'(1);
            end
            // First DONE cycle captures the finished sum; later cycles wait for the handshake.
            if (r_state == DONE) begin
                if (!r_out_valid) begin
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: directed vectors with hand-computed results for fir_seq_mac (TAPS=8, SHIFT=15).
module tb_fir_seq_mac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    int          n_pass = 0;
    int          n_chk = 0;
    fir_seq_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic wr_coef(input int a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask
    task automatic accept(input logic [15:0] x);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
    endtask
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid timeout", 0, 1);
    endtask
    task automatic consume;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
    task automatic send(input string tag, input logic [15:0] x, input logic [15:0] exp);
        int lat;
        accept(x);
        wait_out(lat);
        check({tag, " latency"}, lat, 9);
        check(tag, out_data, exp);
        consume();
    endtask
    initial begin
        int  lat;
        logic seen;
        do_reset();
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst busy", busy, 0);
        wr_coef(0, 16'h8000);
        send("pass 100", 16'd100, 16'd100);
        send("pass 7", 16'd7, 16'd7);
        send("pass 65535", 16'hFFFF, 16'hFFFF);
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(k, 16'((k + 1) << 12));
        send("imp 0", 16'd800, 16'd100);
        for (int k = 1; k < 8; k++) send($sformatf("imp %0d", k), 16'd0, 16'(100 * (k + 1)));
        send("imp tail", 16'd0, 16'd0);
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(k, 16'hFFFF);
        for (int k = 0; k < 8; k++) send($sformatf("sat %0d", k), 16'hFFFF, 16'hFFFF);
        do_reset();
        wr_coef(0, 16'h8000);
        accept(16'd1234);
        check("bp busy in mac", busy, 1);
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp out_valid held", out_valid, 1);
            check("bp out_data held", out_data, 1234);
            check("bp in_ready low", in_ready, 0);
        end
        consume();
        check("bp out_valid cleared", out_valid, 0);
        check("bp in_ready back", in_ready, 1);
        do_reset();
        wr_coef(0, 16'h8000);
        wr_coef(1, 16'h8000);
        accept(16'd999);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", in_ready, 1);
        check("midrst busy", busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            seen |= out_valid;
            tick();
        end
        check("midrst no output", seen, 0);
        wr_coef(0, 16'h8000);
        wr_coef(1, 16'h8000);
        send("midrst cleared line", 16'd50, 16'd50);
        do_reset();
        wr_coef(0, 16'h4000);
`ifdef FIR_SEQ_MAC_ROUND_EN
        send("round 3", 16'd3, 16'd2);
`else
        send("round 3", 16'd3, 16'd1);
`endif
        do_reset();
        coef_we = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h8000;
        accept(16'd77);
        coef_we = 1'b1;
        coef_data = 16'h0000;
        tick();
        coef_we = 1'b0;
        wait_out(lat);
        check("same-cycle coef", out_data, 77);
        consume();
        send("coef ignored in mac", 16'd5, 16'd5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
